// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs, mux selects and the state enum.
// MIPS_MC_BNE_EN adds the bne opcode and its BNE_BR state.
package mips_mc_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JMP  = 2'b10;
  localparam logic [1:0] PC_SRC_REGA = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
`ifdef MIPS_MC_BNE_EN
    , S_BNE_BR
`endif
  } state_t;

  function automatic logic func_known(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR) || (f == FN_SLT);
  endfunction

  function automatic logic [2:0] func_alu_opc(input logic [5:0] f);
    case (f)
      FN_SUB, FN_SLT: return ALU_SUB;
      FN_AND:         return ALU_AND;
      FN_OR:          return ALU_OR;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_next_state.sv
// Combinational next-state decode for the multi-cycle MIPS controller.
// MIPS_MC_BNE_EN routes opcode 000101 to BNE_BR; otherwise it falls back to FETCH.
module mips_mc_next_state
  import mips_mc_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_func,
  output logic [STATE_W-1:0] o_next
);

  always_comb begin
    o_next = S_FETCH;
    case (state_t'(i_state))
      S_FETCH: o_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW:    o_next = S_MEM_ADDR;
          OP_RTYPE:        o_next = (i_func == FN_JR) ? S_JR : S_R_EXEC;
          OP_ADDI, OP_SLTI: o_next = S_I_EXEC;
          OP_BEQ:          o_next = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:          o_next = S_BNE_BR;
`endif
          OP_J:            o_next = S_JUMP;
          OP_JAL:          o_next = S_JAL;
          default:         o_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: o_next = (i_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   o_next = S_MEM_WB;
      S_R_EXEC:   o_next = S_R_WB;
      S_I_EXEC:   o_next = S_I_WB;
      default:    o_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore controller for the shared multi-cycle MIPS datapath; state register plus output decode.
// Build with MIPS_MC_BNE_EN to add bne (branch taken on ~zero).
module mips_multicycle_controller
  import mips_mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  output logic               pc_wr_en,
  output logic               pc_wr_cond,
  output logic               pc_ld_en,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               ir_wr_en,
  output logic               reg_wr_en,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_opc,
  output logic               slt_alu_sel,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
);

  state_t               r_state;
  logic [STATE_W-1:0]   w_next;
  logic                 w_taken;

  mips_mc_next_state u_next (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_func   (func),
    .o_next   (w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= state_t'(w_next);
  end

  assign state_o = r_state;

  // Outputs follow the current state; rst gates them so an aborted instruction writes nothing.
  always_comb begin
    pc_wr_en    = 1'b0;
    pc_wr_cond  = 1'b0;
    pc_src      = PC_SRC_ALU;
    i_or_d      = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    ir_wr_en    = 1'b0;
    reg_wr_en   = 1'b0;
    reg_dst     = DST_RT;
    mem_to_reg  = M2R_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_opc     = ALU_ADD;
    slt_alu_sel = 1'b0;
    instr_done  = 1'b0;
    w_taken     = zero;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_rd_en = 1'b1;
          ir_wr_en  = 1'b1;
          alu_src_b = SRCB_4;
          pc_src    = PC_SRC_ALU;
          pc_wr_en  = 1'b1;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_BOFF;
          instr_done = (w_next == S_FETCH);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          i_or_d    = 1'b1;
          mem_rd_en = 1'b1;
        end
        S_MEM_WB: begin
          reg_wr_en  = 1'b1;
          reg_dst    = DST_RT;
          mem_to_reg = M2R_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          i_or_d     = 1'b1;
          mem_wr_en  = 1'b1;
          instr_done = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_opc   = func_alu_opc(func);
        end
        S_R_WB: begin
          reg_wr_en   = func_known(func);
          reg_dst     = DST_RD;
          mem_to_reg  = M2R_ALU;
          slt_alu_sel = (func != FN_SLT);
          instr_done  = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_opc   = (opcode == OP_SLTI) ? ALU_SUB : ALU_ADD;
        end
        S_I_WB: begin
          reg_wr_en   = 1'b1;
          reg_dst     = DST_RT;
          mem_to_reg  = M2R_ALU;
          slt_alu_sel = (opcode == OP_ADDI);
          instr_done  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_opc    = ALU_SUB;
          pc_wr_cond = 1'b1;
          pc_src     = PC_SRC_BR;
          instr_done = 1'b1;
        end
`ifdef MIPS_MC_BNE_EN
        S_BNE_BR: begin
          alu_src_a  = 1'b1;
          alu_opc    = ALU_SUB;
          pc_wr_cond = 1'b1;
          pc_src     = PC_SRC_BR;
          instr_done = 1'b1;
          w_taken    = ~zero;
        end
`endif
        S_JUMP: begin
          pc_src     = PC_SRC_JMP;
          pc_wr_en   = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          pc_src     = PC_SRC_JMP;
          pc_wr_en   = 1'b1;
          reg_wr_en  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_src     = PC_SRC_REGA;
          pc_wr_en   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
    pc_ld_en = pc_wr_en | (pc_wr_cond & w_taken);
  end

endmodule
